// File: rtl/mem_stage_lsu_if.sv
// Bundle of request, data-memory and MEM/WB signals for the load/store unit.
//   slave  : the LSU side (takes requests, drives memory controls and the MEM/WB entry)
//   master : the pipeline/memory side (issues requests, returns read data, consumes entries)
interface mem_stage_lsu_if #(parameter int ADDR_W = 16);
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic              in_load;
  logic              in_store;
  logic [2:0]        in_funct3;
  logic [31:0]       in_addr;
  logic [31:0]       in_wdata;
  logic [4:0]        in_rd;
  logic [3:0]        dm_w_en;
  logic [ADDR_W-1:0] dm_address;
  logic [31:0]       dm_write_data;
  logic [31:0]       dm_read_data;
  logic              out_valid;
  logic              out_ready;
  logic [4:0]        out_rd;
  logic [31:0]       out_data;
  logic [1:0]        out_fault;

  modport slave (
    input  flush, in_valid, in_load, in_store, in_funct3, in_addr, in_wdata, in_rd,
           dm_read_data, out_ready,
    output in_ready, dm_w_en, dm_address, dm_write_data,
           out_valid, out_rd, out_data, out_fault
  );

  modport master (
    output flush, in_valid, in_load, in_store, in_funct3, in_addr, in_wdata, in_rd,
           dm_read_data, out_ready,
    input  in_ready, dm_w_en, dm_address, dm_write_data,
           out_valid, out_rd, out_data, out_fault
  );
endinterface

// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit.
// Validates each EX/MEM request, drives the byte-addressed data memory (write
// enables, address, write data), extends load data and registers the result
// into a stallable MEM/WB entry with a valid/ready handshake.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   bus        : mem_stage_lsu_if.slave (request, data memory, MEM/WB entry)
//   cnt_load   : fault-free loads accepted
//   cnt_store  : fault-free stores accepted
//   cnt_fault  : faulting memory ops accepted
module mem_stage_lsu #(
  parameter int ADDR_W = 16,
  parameter int CNT_W  = 32
) (
  input  logic             clk,
  input  logic             rst,
  mem_stage_lsu_if.slave   bus,
  output logic [CNT_W-1:0] cnt_load,
  output logic [CNT_W-1:0] cnt_store,
  output logic [CNT_W-1:0] cnt_fault
);

  typedef enum logic [1:0] {
    F_NONE     = 2'b00,
    F_MISALIGN = 2'b01,
    F_RANGE    = 2'b10,
    F_ILLEGAL  = 2'b11
  } fault_e;

  logic        accept;
  logic        illegal;
  logic        misaligned;
  logic        out_of_range;
  fault_e      fault;
  logic [31:0] load_data;
  logic [31:0] next_data;
  logic [4:0]  next_rd;

  logic        valid_q;
  logic [4:0]  rd_q;
  logic [31:0] data_q;
  fault_e      fault_q;

  // The entry can take a new request when empty or being drained this cycle.
  assign bus.in_ready      = !rst && (!valid_q || bus.out_ready);
  assign accept            = bus.in_valid && bus.in_ready && !bus.flush;

  // Memory places byte k at address+k, so store data goes out unshifted.
  assign bus.dm_address    = bus.in_addr[ADDR_W-1:0];
  assign bus.dm_write_data = bus.in_wdata;

  always_comb begin
    illegal = (bus.in_load && bus.in_store)
           || (bus.in_load  && (bus.in_funct3 == 3'b011 || bus.in_funct3[2:1] == 2'b11))
           || (bus.in_store && bus.in_funct3 >= 3'b011);
    // funct3[1:0] encodes access size: 00 byte, 01 half, 10 word.
    misaligned = (bus.in_funct3[1:0] == 2'b01 && bus.in_addr[0])
              || (bus.in_funct3[1:0] == 2'b10 && bus.in_addr[1:0] != 2'b00);
    out_of_range = (bus.in_addr >> ADDR_W) != 32'd0;

    fault = F_NONE;
    if (bus.in_load || bus.in_store) begin
      if (illegal)           fault = F_ILLEGAL;
      else if (misaligned)   fault = F_MISALIGN;
      else if (out_of_range) fault = F_RANGE;
    end
  end

  // Any nonzero enable turns the memory read path off, so only a clean
  // accepted store may raise it.
  always_comb begin
    bus.dm_w_en = 4'b0000;
    if (accept && bus.in_store && fault == F_NONE) begin
      case (bus.in_funct3[1:0])
        2'b00:   bus.dm_w_en = 4'b0001;
        2'b01:   bus.dm_w_en = 4'b0011;
        default: bus.dm_w_en = 4'b1111;
      endcase
    end
  end

  always_comb begin
    case (bus.in_funct3)
      3'b000:  load_data = {{24{bus.dm_read_data[7]}}, bus.dm_read_data[7:0]};
      3'b100:  load_data = {24'd0, bus.dm_read_data[7:0]};
      3'b001:  load_data = {{16{bus.dm_read_data[15]}}, bus.dm_read_data[15:0]};
      3'b101:  load_data = {16'd0, bus.dm_read_data[15:0]};
      default: load_data = bus.dm_read_data;
    endcase

    next_data = bus.in_addr;
    next_rd   = bus.in_rd;
    if (fault != F_NONE || bus.in_store) begin
      next_data = 32'd0;
      next_rd   = 5'd0;
    end else if (bus.in_load) begin
      next_data = load_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q   <= 1'b0;
      rd_q      <= 5'd0;
      data_q    <= 32'd0;
      fault_q   <= F_NONE;
      cnt_load  <= '0;
      cnt_store <= '0;
      cnt_fault <= '0;
    end else begin
      if (accept) begin
        valid_q <= 1'b1;
        rd_q    <= next_rd;
        data_q  <= next_data;
        fault_q <= fault;
        if (fault != F_NONE)   cnt_fault <= cnt_fault + CNT_W'(1);
        else if (bus.in_load)  cnt_load  <= cnt_load  + CNT_W'(1);
        else if (bus.in_store) cnt_store <= cnt_store + CNT_W'(1);
      end else if (bus.flush || bus.out_ready) begin
        // Drain or flush: only valid drops, data fields keep their values.
        valid_q <= 1'b0;
      end
    end
  end

  assign bus.out_valid = valid_q;
  assign bus.out_rd    = rd_q;
  assign bus.out_data  = data_q;
  assign bus.out_fault = fault_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
module tb_mem_stage_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] cnt_load, cnt_store, cnt_fault;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  mem_stage_lsu_if #(.ADDR_W(16)) bus ();

  mem_stage_lsu #(.ADDR_W(16), .CNT_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .cnt_load  (cnt_load),
    .cnt_store (cnt_store),
    .cnt_fault (cnt_fault)
  );

  // Environment memory (written from the DUT's enables) and the reference copy
  // (written by the model); they diverge if the DUT writes wrongly.
  logic [7:0]  env_mem [65536];
  logic [7:0]  ref_mem [65536];
  logic        rd_ovr;
  logic [31:0] rd_ovr_val;
  logic [15:0] a0, a1, a2, a3;

  assign a0 = bus.dm_address;
  assign a1 = a0 + 16'd1;
  assign a2 = a0 + 16'd2;
  assign a3 = a0 + 16'd3;
  assign bus.dm_read_data = rd_ovr ? rd_ovr_val
                                   : {env_mem[a3], env_mem[a2], env_mem[a1], env_mem[a0]};

  typedef struct packed {
    logic        v, ld, st;
    logic [2:0]  f3;
    logic [31:0] a, wd;
    logic [4:0]  rd;
  } req_t;

  typedef struct packed {
    logic        rdy;
    logic [3:0]  wen;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic        vld;
    logic [1:0]  flt;
    logic [4:0]  rd;
    logic [31:0] data;
    logic [31:0] cl, cs, cf;
  } obs_t;

  // Reference model state: the MEM/WB entry and counters as the rules define them.
  logic        mv;
  logic [1:0]  mflt;
  logic [4:0]  mrd;
  logic [31:0] mdata;
  logic [31:0] ml, ms, mf;

  function automatic req_t mk(input logic ld, input logic st, input logic [2:0] f3,
                              input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd);
    req_t r;
    r.v = 1'b1; r.ld = ld; r.st = st; r.f3 = f3; r.a = a; r.wd = wd; r.rd = rd;
    return r;
  endfunction

  task automatic model_reset();
    mv = 1'b0; mflt = 2'b00; mrd = 5'd0; mdata = 32'd0;
    ml = 32'd0; ms = 32'd0; mf = 32'd0;
  endtask

  task automatic model_step(input req_t r, input logic fl, input logic ordy, output obs_t e);
    logic        rdy, acc;
    logic [1:0]  flt;
    logic [31:0] v;
    int          nb;
    rdy = !mv || ordy;
    acc = r.v && rdy && !fl;
    nb  = 1 << r.f3[1:0];
    flt = 2'b00;
    if (r.ld || r.st) begin
      if ((r.ld && r.st) || (r.ld && r.f3 inside {3'd3, 3'd6, 3'd7}) || (r.st && r.f3 >= 3'd3))
        flt = 2'b11;
      else if (r.a % nb != 0) flt = 2'b01;
      else if (r.a > 32'h0000FFFF) flt = 2'b10;
    end
    e       = '0;
    e.rdy   = rdy;
    e.addr  = r.a[15:0];
    e.wdata = r.wd;
    if (acc) begin
      v = 32'd0;
      if (flt != 2'b00) begin
        mf = mf + 1;
      end else if (r.ld) begin
        for (int k = 0; k < nb; k++) v = v | (32'(ref_mem[16'(r.a[15:0] + 16'(k))]) << (8 * k));
        if (!r.f3[2] && nb < 4 && v[8 * nb - 1]) v = v | (32'hFFFFFFFF << (8 * nb));
        ml = ml + 1;
      end else if (r.st) begin
        e.wen = 4'((1 << nb) - 1);
        for (int k = 0; k < nb; k++) ref_mem[16'(r.a[15:0] + 16'(k))] = r.wd[8 * k +: 8];
        ms = ms + 1;
      end else begin
        v = r.a;
      end
      mv    = 1'b1;
      mflt  = flt;
      mdata = v;
      mrd   = (flt != 2'b00 || r.st) ? 5'd0 : r.rd;
    end else if (fl || ordy) begin
      mv = 1'b0;
    end
    e.vld = mv; e.flt = mflt; e.rd = mrd; e.data = mdata;
    e.cl = ml; e.cs = ms; e.cf = mf;
  endtask

  // One clock of stimulus; captures combinational outputs mid-cycle and
  // registered outputs just after the edge, then commits any memory write.
  task automatic xfer(input req_t r, input logic fl, input logic ordy, output obs_t o);
    bus.in_valid = r.v; bus.in_load = r.ld; bus.in_store = r.st; bus.in_funct3 = r.f3;
    bus.in_addr = r.a; bus.in_wdata = r.wd; bus.in_rd = r.rd;
    bus.flush = fl; bus.out_ready = ordy;
    @(negedge clk);
    o.rdy = bus.in_ready; o.wen = bus.dm_w_en; o.addr = bus.dm_address; o.wdata = bus.dm_write_data;
    @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) if (o.wen[k]) env_mem[16'(o.addr + 16'(k))] = o.wdata[8 * k +: 8];
    o.vld = bus.out_valid; o.flt = bus.out_fault; o.rd = bus.out_rd; o.data = bus.out_data;
    o.cl = cnt_load; o.cs = cnt_store; o.cf = cnt_fault;
  endtask

  task automatic run(input req_t r, input logic fl, input logic ordy, output obs_t e, output obs_t o);
    model_step(r, fl, ordy, e);
    xfer(r, fl, ordy, o);
  endtask

  task automatic test_reset();
    obs_t o;
    rst = 1'b1;
    xfer(mk(1'b0, 1'b1, 3'b010, 32'h20, 32'h12345678, 5'd5), 1'b0, 1'b1, o);
    xfer(mk(1'b0, 1'b1, 3'b010, 32'h20, 32'h12345678, 5'd5), 1'b0, 1'b1, o);
    model_reset();
    checks++;
    if (o.rdy !== 1'b0 || o.wen !== 4'b0000) begin
      errors++; $display("FAIL reset_handshake got rdy=%b wen=%b exp rdy=0 wen=0000", o.rdy, o.wen);
    end
    checks++;
    if ({o.vld, o.flt, o.rd, o.data, o.cl, o.cs, o.cf} !== '0) begin
      errors++; $display("FAIL reset_state got vld=%b flt=%b rd=%0d data=%h cnt=%0d/%0d/%0d exp all 0",
                         o.vld, o.flt, o.rd, o.data, o.cl, o.cs, o.cf);
    end
    rst = 1'b0;
  endtask

  task automatic test_byte();
    obs_t e, o;
    run(mk(1'b0, 1'b1, 3'b000, 32'h3, 32'hAABBCCDD, 5'd7), 1'b0, 1'b1, e, o);
    checks++;
    if (o !== e) begin errors++; $display("FAIL sb got %h exp %h", o, e); end
    checks++;
    if (o.wen !== 4'b0001 || o.addr !== 16'h0003 || o.cs !== 32'd1) begin
      errors++; $display("FAIL sb_plan got wen=%b addr=%h cs=%0d exp 0001 0003 1", o.wen, o.addr, o.cs);
    end
    run(mk(1'b1, 1'b0, 3'b100, 32'h3, 32'h0, 5'd8), 1'b0, 1'b1, e, o);
    checks++;
    if (o !== e || o.data !== 32'h000000DD) begin
      errors++; $display("FAIL lbu got %h exp %h", o, e);
    end
    run(mk(1'b1, 1'b0, 3'b000, 32'h3, 32'h0, 5'd9), 1'b0, 1'b1, e, o);
    checks++;
    if (o !== e || o.data !== 32'hFFFFFFDD || o.rd !== 5'd9) begin
      errors++; $display("FAIL lb got %h exp %h", o, e);
    end
  endtask

  task automatic test_half();
    obs_t e, o;
    run(mk(1'b0, 1'b1, 3'b010, 32'h10, 32'h80017F02, 5'd1), 1'b0, 1'b1, e, o);
    checks++;
    if (o !== e || o.wen !== 4'b1111) begin errors++; $display("FAIL sw got %h exp %h", o, e); end
    run(mk(1'b1, 1'b0, 3'b001, 32'h10, 32'h0, 5'd2), 1'b0, 1'b1, e, o);
    checks++;
    if (o !== e || o.data !== 32'h00007F02) begin errors++; $display("FAIL lh_lo got %h exp %h", o, e); end
    run(mk(1'b1, 1'b0, 3'b001, 32'h12, 32'h0, 5'd3), 1'b0, 1'b1, e, o);
    checks++;
    if (o !== e || o.data !== 32'hFFFF8001) begin errors++; $display("FAIL lh_hi got %h exp %h", o, e); end
    run(mk(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 5'd4), 1'b0, 1'b1, e, o);
    checks++;
    if (o !== e || o.data !== 32'h80017F02) begin errors++; $display("FAIL lw got %h exp %h", o, e); end
  endtask

  task automatic test_faults();
    obs_t e, o;
    run(mk(1'b1, 1'b0, 3'b010, 32'h11, 32'h0, 5'd6), 1'b0, 1'b1, e, o);
    checks++;
    if (o !== e || o.flt !== 2'b01 || o.rd !== 5'd0) begin
      errors++; $display("FAIL misalign got %h exp %h", o, e);
    end
    run(mk(1'b0, 1'b1, 3'b001, 32'h00010000, 32'h5555, 5'd6), 1'b0, 1'b1, e, o);
    checks++;
    if (o !== e || o.flt !== 2'b10 || o.wen !== 4'b0000 || o.rd !== 5'd0) begin
      errors++; $display("FAIL range got %h exp %h", o, e);
    end
    run(mk(1'b1, 1'b0, 3'b011, 32'h20, 32'h0, 5'd6), 1'b0, 1'b1, e, o);
    checks++;
    if (o !== e || o.flt !== 2'b11 || o.rd !== 5'd0 || o.cf !== 32'd3) begin
      errors++; $display("FAIL illegal got %h exp %h", o, e);
    end
  endtask

  task automatic test_backpressure();
    obs_t e, o;
    run(mk(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 5'd10), 1'b0, 1'b1, e, o);
    checks++;
    if (o !== e) begin errors++; $display("FAIL bp_load got %h exp %h", o, e); end
    for (int i = 0; i < 3; i++) begin
      rd_ovr = 1'b1; rd_ovr_val = $urandom;
      run(mk(1'b1, 1'b0, 3'b010, 32'(4 * $urandom_range(0, 15)), 32'h0, 5'd11), 1'b0, 1'b0, e, o);
      checks++;
      if (o !== e || o.data !== 32'h80017F02 || o.rdy !== 1'b0 || o.vld !== 1'b1) begin
        errors++; $display("FAIL bp_hold%0d got %h exp %h", i, o, e);
      end
    end
    rd_ovr = 1'b0;
    run(mk(1'b1, 1'b0, 3'b100, 32'h3, 32'h0, 5'd12), 1'b0, 1'b1, e, o);
    checks++;
    if (o !== e || o.rdy !== 1'b1 || o.vld !== 1'b1 || o.data !== 32'h000000DD) begin
      errors++; $display("FAIL bp_release got %h exp %h", o, e);
    end
  endtask

  task automatic test_flush();
    obs_t e, o;
    req_t idle;
    idle = mk(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0);
    idle.v = 1'b0;
    run(mk(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 5'd13), 1'b0, 1'b1, e, o);
    run(idle, 1'b0, 1'b0, e, o);
    checks++;
    if (o !== e || o.vld !== 1'b1) begin errors++; $display("FAIL flush_stall got %h exp %h", o, e); end
    run(mk(1'b0, 1'b1, 3'b010, 32'h40, 32'hDEADBEEF, 5'd14), 1'b1, 1'b0, e, o);
    checks++;
    if (o !== e || o.wen !== 4'b0000 || o.vld !== 1'b0) begin
      errors++; $display("FAIL flush got %h exp %h", o, e);
    end
    run(mk(1'b1, 1'b0, 3'b010, 32'h40, 32'h0, 5'd15), 1'b0, 1'b1, e, o);
    checks++;
    if (o !== e) begin errors++; $display("FAIL flush_nowrite got %h exp %h", o, e); end
  endtask

  task automatic test_random();
    obs_t e, o;
    req_t r;
    int   bad = 0;
    for (int i = 0; i < 400; i++) begin
      r.v  = ($urandom_range(0, 9) < 8);
      case ($urandom_range(0, 6))
        0, 1:    begin r.ld = 1'b1; r.st = 1'b0; end
        2, 3:    begin r.ld = 1'b0; r.st = 1'b1; end
        4, 5:    begin r.ld = 1'b0; r.st = 1'b0; end
        default: begin r.ld = 1'b1; r.st = 1'b1; end
      endcase
      r.f3 = ($urandom_range(0, 4) == 0) ? 3'($urandom) : 3'($urandom_range(0, 2));
      if (r.ld && $urandom_range(0, 1) == 1 && r.f3 != 3'd2) r.f3[2] = 1'b1;
      r.a  = ($urandom_range(0, 11) == 0) ? $urandom : 32'($urandom_range(0, 127));
      r.wd = $urandom;
      r.rd = 5'($urandom);
      run(r, ($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0), e, o);
      checks++;
      if (o !== e) begin
        errors++; bad++;
        if (bad <= 5) $display("FAIL random%0d got %h exp %h", i, o, e);
      end
    end
  endtask

  task automatic test_reset_mid_stall();
    obs_t e, o;
    run(mk(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 5'd16), 1'b0, 1'b1, e, o);
    run(mk(1'b0, 1'b1, 3'b010, 32'h48, 32'hCAFEF00D, 5'd17), 1'b0, 1'b0, e, o);
    rst = 1'b1;
    xfer(mk(1'b0, 1'b1, 3'b010, 32'h48, 32'hCAFEF00D, 5'd17), 1'b0, 1'b1, o);
    model_reset();
    checks++;
    if (o.rdy !== 1'b0 || o.wen !== 4'b0000 ||
        {o.vld, o.flt, o.rd, o.data, o.cl, o.cs, o.cf} !== '0) begin
      errors++; $display("FAIL rst_stall got %h exp rdy=0 wen=0 state 0", o);
    end
    rst = 1'b0;
    run(mk(1'b1, 1'b0, 3'b010, 32'h48, 32'h0, 5'd18), 1'b0, 1'b1, e, o);
    checks++;
    if (o !== e || o.cl !== 32'd1) begin errors++; $display("FAIL rst_nowrite got %h exp %h", o, e); end
  endtask

  initial begin
    logic [7:0] b;
    rst = 1'b1; rd_ovr = 1'b0; rd_ovr_val = 32'd0;
    bus.flush = 1'b0; bus.in_valid = 1'b0; bus.in_load = 1'b0; bus.in_store = 1'b0;
    bus.in_funct3 = 3'd0; bus.in_addr = 32'd0; bus.in_wdata = 32'd0; bus.in_rd = 5'd0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 65536; i++) begin
      b = 8'($urandom);
      env_mem[i] = b;
      ref_mem[i] = b;
    end
    model_reset();
    test_reset();
    test_byte();
    test_half();
    test_faults();
    test_backpressure();
    test_flush();
    test_random();
    test_reset_mid_stall();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
- Memory-stage load/store unit between the EX/MEM pipeline register and the byte-addressed data memory.
- Validates each access and generates the data memory's 4-bit byte write enables, 16-bit address and write data.
- Sign- or zero-extends load data and registers the result into a stallable MEM/WB output register with a valid/ready handshake.
- Keeps access and fault counters.

Parameters:
- ADDR_W, 16, data memory address width; in_addr bits above ADDR_W-1 must be zero.
- CNT_W, 32, width of each statistics counter.

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous active-high reset
- flush  in  1  kill the incoming request this cycle and clear the output register
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when in_valid&&in_ready&&!flush
- in_load  in  1  request is a load
- in_store  in  1  request is a store
- in_funct3  in  3  RISC-V funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW)
- in_addr  in  32  effective address, or ALU result for non-memory ops
- in_wdata  in  32  store data, unshifted
- in_rd  in  5  destination register
- dm_w_en  out  4  byte write enables to data memory
- dm_address  out  ADDR_W  data memory byte address
- dm_write_data  out  32  data memory write data
- dm_read_data  in  32  combinational data memory read data, little-endian from dm_address
- out_valid  out  1  MEM/WB entry valid
- out_ready  in  1  writeback consumes the entry
- out_rd  out  5  destination register (0 for stores and faults)
- out_data  out  32  load result or passed-through ALU result
- out_fault  out  2  00 none, 01 misaligned, 10 out of range, 11 illegal
- cnt_load, cnt_store, cnt_fault  out  CNT_W each  statistics counters

Behaviour:
- Reset (synchronous, rst=1 at posedge):
  - out_valid, out_rd, out_data, out_fault and all counters go to 0.
  - While rst=1, in_ready=0 and dm_w_en=0.
- in_ready = !rst && (!out_valid || out_ready), combinational.
- accept = in_valid && in_ready && !flush.
- dm_address = in_addr[ADDR_W-1:0] and dm_write_data = in_wdata, always. The memory stores byte k at address+k, so no lane shifting is applied.
- Fault classification (combinational, priority order):
  - illegal (11): in_load&&in_store, or a funct3 undefined for the operation (load 011/110/111; store 011 and above).
  - misaligned (01): halfword with addr[0]=1, or word with addr[1:0]!=0.
  - range (10): in_addr[31:ADDR_W]!=0.
  - Non-memory ops (in_load=in_store=0) never fault.
- dm_w_en:
  - Nonzero only for accept && in_store && no fault: SB=0001, SH=0011, SW=1111.
  - 0 for loads, faults, flush, stalls and idle. The memory's read path is live only when w_en=0, so loads rely on this.
- Load extension from dm_read_data in the accept cycle:
  - LB sign-extends [7:0]; LBU zero-extends [7:0].
  - LH sign-extends [15:0]; LHU zero-extends [15:0].
  - LW passes all 32 bits.
- Output register, one-cycle latency: on accept, at the next edge:
  - out_valid=1 and out_fault = classification.
  - out_data = extended load data (load), 0 (store or fault), or in_addr (non-memory).
  - out_rd = in_rd, except 0 for stores and faults.
- Stall: while out_valid && !out_ready, the register holds all fields unchanged regardless of in_addr or dm_read_data changes, and in_ready=0.
- Drain: out_ready && !accept clears out_valid at the next edge; the data fields hold their values.
- Simultaneous drain and accept: the register is overwritten with the new entry with no bubble, giving back-to-back throughput of 1 per cycle.
- flush=1: no accept and no write that cycle; out_valid=0 at the next edge, overriding a stalled entry. Counters are not affected.
- Counters, on accept only, wrapping modulo 2^CNT_W:
  - cnt_load increments for a fault-free load.
  - cnt_store increments for a fault-free store.
  - cnt_fault increments for any fault.

Test Plan:
- SB addr=0x0003 wdata=0xAABBCCDD, accepted -> dm_w_en=0001 and dm_address=0x0003 in that cycle; cnt_store=1. Then LBU addr=0x0003 -> out_data=0x000000DD; LB -> 0xFFFFFFDD.
- SW addr=0x0010 data=0x80017F02, then LH 0x0010 -> out_data=0x00007F02; LH 0x0012 -> 0xFFFF8001; LW 0x0010 -> 0x80017F02.
- Faults: LW addr=0x0011 -> out_fault=01; SH addr=0x00010000 -> out_fault=10 with dm_w_en=0; funct3=011 load -> out_fault=11. In all three cases out_rd=0 and cnt_fault increments, ending at 3.
- Back-pressure: hold out_ready=0 for 3 cycles after LW 0x0010 while in_addr and dm_read_data change -> out_data stays 0x80017F02 and in_ready=0. Raising out_ready with a new request pending -> next entry lands at the next edge with no bubble.
- flush with in_valid=1 store and a stalled entry -> dm_w_en=0 in that cycle, out_valid=0 at the next edge, counters unchanged.
- rst asserted mid-stall -> all outputs and counters 0 at the next edge; a pending store is not written.
